// File: rtl/bus_arb_rr.sv
// Purpose : round-robin arbiter/sequencer for one shared broadcast bus segment;
//           picks one pending driver FIFO, pops one packet, pushes it to its
//           destination terminal (or to every other terminal on broadcast).
// Latency : pndng seen in IDLE cycle n -> pop in n+1 -> push/D_push in n+2 -> IDLE in n+3.
// Backpr. : none on the receive side; senders are throttled by the one-packet-per-3-cycle
//           pop cadence and pndng is only sampled in IDLE.
// Ports   : clk, reset (async, active-low), pndng/D_pop per-terminal FWFT FIFO heads,
//           pop one-hot pop strobe, push/D_push receiver strobes and replicated packet,
//           busy (not IDLE), grant (terminal served / last served), drop_cnt (saturating).
// Option  : BUS_ARB_BCAST_EN enables broadcast delivery; without it the BROADCAST
//           ID is treated as an out-of-range destination and dropped.
module bus_arb_rr #(
   parameter int         DRVRS     = 4,
   parameter int         PCKG_SZ   = 16,
   parameter logic [7:0] BROADCAST = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DRVRS-1:0]           pndng,
   input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
   output logic [DRVRS-1:0]           pop,
   output logic [DRVRS-1:0]           push,
   output logic [DRVRS*PCKG_SZ-1:0]   D_push,
   output logic                       busy,
   output logic [$clog2(DRVRS)-1:0]   grant,
   output logic [7:0]                 drop_cnt
);

   localparam int GW = $clog2(DRVRS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        grant_q;
   logic [GW-1:0]        last_q;
   logic [GW-1:0]        sel;
   logic                 found;
   logic [PCKG_SZ-1:0]   pkt_q;
   logic [PCKG_SZ-1:0]   lane;
   logic [7:0]           drop_q;
   logic [7:0]           dest;
   logic [DRVRS-1:0]     dest_vec;
   logic                 drop;

   // Round-robin search: the smallest distance k (1..DRVRS) past last_q wins,
   // so the last-served terminal is considered only when nobody else is pending.
   always_comb begin
      sel   = grant_q;
      found = 1'b0;
      for (int k = 1; k <= DRVRS; k++) begin
         for (int i = 0; i < DRVRS; i++) begin
            if (!found && pndng[i] && (i == (int'(last_q) + k) % DRVRS)) begin
               found = 1'b1;
               sel   = GW'(i);
            end
         end
      end
   end

   // Head-of-FIFO lane of the granted terminal.
   always_comb begin
      lane = '0;
      for (int i = 0; i < DRVRS; i++) begin
         if (GW'(i) == grant_q) begin
            lane = D_pop[i*PCKG_SZ +: PCKG_SZ];
         end
      end
   end

   // Destination decode; the source terminal never receives its own packet,
   // which makes self-addressed packets decode to an empty vector (a drop).
   assign dest = pkt_q[PCKG_SZ-1 -: 8];

   always_comb begin
      dest_vec = '0;
      for (int i = 0; i < DRVRS; i++) begin
         if (GW'(i) != grant_q) begin
            if (dest == 8'(i)) begin
               dest_vec[i] = 1'b1;
            end
`ifdef BUS_ARB_BCAST_EN
            if (dest == BROADCAST) begin
               dest_vec[i] = 1'b1;
            end
`endif
         end
      end
   end

   assign drop = (state_q == PUSH) && (dest_vec == '0);

   // Next state and strobes.
   always_comb begin
      state_d = state_q;
      pop     = '0;
      push    = '0;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (|pndng) begin
               state_d = POP;
            end
         end
         POP: begin
            for (int i = 0; i < DRVRS; i++) begin
               if (GW'(i) == grant_q) begin
                  pop[i] = 1'b1;
               end
            end
            state_d = PUSH;
         end
         PUSH: begin
            push    = dest_vec;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // last_q resets to DRVRS-1 so the first search starts at terminal 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q <= '0;
         last_q  <= GW'(DRVRS - 1);
         pkt_q   <= '0;
         drop_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|pndng) begin
                  grant_q <= sel;
               end
            end
            POP: begin
               pkt_q <= lane;
            end
            PUSH: begin
               last_q <= grant_q;
               if (drop && (drop_q != 8'hFF)) begin
                  drop_q <= drop_q + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign D_push   = {DRVRS{pkt_q}};
   assign grant    = grant_q;
   assign drop_cnt = drop_q;

endmodule
